mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Two-port arbiter that shares the single main-memory line interface between the instruction cache (fetch stage) and the data cache (memory stage). Each cache presents a line read or write request and holds it until it sees its ready. The arbiter latches one request, drives it to memory until memory signals ready, then returns the line and ready pulse to the granted cache only. Ties are broken round-robin.

Parameters:
CACHE_LINE_SIZE, 128, width in bits of one cache line on every data bus.
ADDR_WIDTH, 32, width of every address bus.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
in_i_read_en  in  1  icache line read request
in_i_write_en  in  1  icache line write request (normally 0)
in_i_addr  in  ADDR_WIDTH  icache request address
in_i_write_data  in  CACHE_LINE_SIZE  icache write line
out_i_read_data  out  CACHE_LINE_SIZE  line returned to icache
out_i_ready  out  1  icache transaction complete
in_d_read_en  in  1  dcache line read request
in_d_write_en  in  1  dcache line write-back request
in_d_addr  in  ADDR_WIDTH  dcache request address
in_d_write_data  in  CACHE_LINE_SIZE  dcache write line
out_d_read_data  out  CACHE_LINE_SIZE  line returned to dcache
out_d_ready  out  1  dcache transaction complete
out_mem_read_en  out  1  memory read strobe
out_mem_write_en  out  1  memory write strobe
out_mem_addr  out  ADDR_WIDTH  memory address
out_mem_write_data  out  CACHE_LINE_SIZE  memory write line
in_mem_read_data  in  CACHE_LINE_SIZE  memory read line
in_mem_ready  in  1  memory transaction complete
out_grant  out  2  current owner: 00 none, 01 icache, 10 dcache

Behaviour:
- Reset (asynchronous, any state): FSM to IDLE. Latched op, addr and data cleared. last_grant set to ICACHE. Every output is 0.
- Request definition: req_x = in_x_read_en | in_x_write_en.
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE: all memory outputs 0; both readies 0; in_mem_ready ignored.
  - Only req_i: go to BUSY_I.
  - Only req_d: go to BUSY_D.
  - Both: grant the port that is not last_grant. The first tie after reset therefore goes to dcache.
  - On the grant edge, latch that port's addr and write_data. Latch op as write if its write_en=1, else read; write wins if both enables are high.
- BUSY_x:
  - out_mem_addr and out_mem_write_data come from the latched registers.
  - out_mem_write_en = latched op is write; out_mem_read_en = latched op is read. Both held steady until in_mem_ready.
  - out_grant = 01 (BUSY_I) or 10 (BUSY_D).
- Completion: in the BUSY_x cycle where in_mem_ready=1:
  - out_x_ready=1, combinationally in the same cycle.
  - out_x_read_data = in_mem_read_data for read ops; 0 for writes.
  - Next edge: go to IDLE and set last_grant=x.
  - The non-granted port's ready and read_data are always 0.
- Requester input changes while BUSY are ignored; the latched transaction always completes. A requester that drops its request early still gets its ready pulse.
- Latency: a request asserted in IDLE reaches memory 1 cycle later. There is exactly 1 IDLE bubble cycle between back-to-back transactions.
- A pending port is never starved: after any completion, a tie is granted to the other port.
- in_mem_ready must be a single-cycle pulse. If held high, each BUSY cycle with ready=1 completes one transaction.

Test Plan:
- Single icache read, addr 0x200; memory returns ready after 3 cycles with data 0x...DEADBEEF → out_mem_read_en high for 3 cycles at addr 0x200; out_i_ready=1 for 1 cycle with that data; out_d_ready stays 0.
- Simultaneous icache read 0x200 and dcache write-back 0x1000, data 0xA5..A5, first tie after reset → dcache served first (out_grant=10, out_mem_write_en=1). One IDLE cycle follows, then icache served (out_grant=01).
- Repeated ties with memory latency 1 → grants alternate 10, 01, 10, 01; each port receives exactly one ready per transaction.
- Dcache changes addr from 0x1000 to 0x2000 mid-transaction → out_mem_addr stays 0x1000 until ready.
- Dcache asserts read_en and write_en together → out_mem_write_en=1 and out_mem_read_en=0; on completion out_d_read_data=0.
- Reset asserted mid-BUSY_I → all outputs 0 immediately, with no clock edge. After release, a late in_mem_ready is ignored and no ready pulse is produced.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory line port between the icache and dcache.
// One transaction is latched per grant and held until memory signals ready.
module mem_arbiter #(
  parameter int CACHE_LINE_SIZE = 128,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_i_read_en,
  input  logic                       in_i_write_en,
  input  logic [ADDR_WIDTH-1:0]      in_i_addr,
  input  logic [CACHE_LINE_SIZE-1:0] in_i_write_data,
  output logic [CACHE_LINE_SIZE-1:0] out_i_read_data,
  output logic                       out_i_ready,
  input  logic                       in_d_read_en,
  input  logic                       in_d_write_en,
  input  logic [ADDR_WIDTH-1:0]      in_d_addr,
  input  logic [CACHE_LINE_SIZE-1:0] in_d_write_data,
  output logic [CACHE_LINE_SIZE-1:0] out_d_read_data,
  output logic                       out_d_ready,
  output logic                       out_mem_read_en,
  output logic                       out_mem_write_en,
  output logic [ADDR_WIDTH-1:0]      out_mem_addr,
  output logic [CACHE_LINE_SIZE-1:0] out_mem_write_data,
  input  logic [CACHE_LINE_SIZE-1:0] in_mem_read_data,
  input  logic                       in_mem_ready,
  output logic [1:0]                 out_grant
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t state;
  logic   last_d;   // 1 when the dcache owned the most recent completed transaction
  logic   req_i;
  logic   req_d;
  logic   pick_d;

  assign req_i  = in_i_read_en | in_i_write_en;
  assign req_d  = in_d_read_en | in_d_write_en;
  // On a tie the port that did not finish last wins, so neither side starves.
  assign pick_d = req_d & (~req_i | ~last_d);

  // NOTE: sequential state uses non-blocking assignments only, and the asynchronous
  // reset clears every register so all outputs drop to 0 without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      last_d             <= 1'b0;
      out_grant          <= 2'b00;
      out_mem_read_en    <= 1'b0;
      out_mem_write_en   <= 1'b0;
      out_mem_addr       <= '0;
      out_mem_write_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i || req_d) begin
            if (pick_d) begin
              state              <= BUSY_D;
              out_grant          <= 2'b10;
              out_mem_write_en   <= in_d_write_en;
              out_mem_read_en    <= ~in_d_write_en;
              out_mem_addr       <= in_d_addr;
              out_mem_write_data <= in_d_write_data;
            end else begin
              state              <= BUSY_I;
              out_grant          <= 2'b01;
              out_mem_write_en   <= in_i_write_en;
              out_mem_read_en    <= ~in_i_write_en;
              out_mem_addr       <= in_i_addr;
              out_mem_write_data <= in_i_write_data;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (in_mem_ready) begin
            state              <= IDLE;
            last_d             <= (state == BUSY_D);
            out_grant          <= 2'b00;
            out_mem_read_en    <= 1'b0;
            out_mem_write_en   <= 1'b0;
            out_mem_addr       <= '0;
            out_mem_write_data <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completion is reported in the same cycle memory raises ready; writes return no data.
  assign out_i_ready     = (state == BUSY_I) & in_mem_ready;
  assign out_d_ready     = (state == BUSY_D) & in_mem_ready;
  assign out_i_read_data = (out_i_ready & out_mem_read_en) ? in_mem_read_data : '0;
  assign out_d_read_data = (out_d_ready & out_mem_read_en) ? in_mem_read_data : '0;

endmodule
